// File: rtl/rec_f64_pkg.sv
// Shared widths, recoding constants and the stage-1 register layout for the
// binary64 -> recoded binary64 converter.
package rec_f64_pkg;

  localparam int EXP_W     = 11;
  localparam int FRACT_W   = 52;
  localparam int REC_EXP_W = 12;
  localparam int REC_W     = 65;

  localparam logic [REC_EXP_W-1:0] NORM_BIAS_ADJ = 12'h401;
  localparam logic [REC_EXP_W-1:0] SUB_BIAS_ADJ  = 12'h402;
  localparam logic [REC_EXP_W-1:0] REC_INF_EXP   = 12'hC00;
  localparam logic [REC_EXP_W-1:0] REC_NAN_EXP   = 12'hE00;
  localparam logic [REC_W-1:0]     CANON_NAN     = 65'h0_E008000000000000;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               sub;
    logic               inf;
    logic               nan;
    logic               snan;
    logic [EXP_W-1:0]   e;
    logic [FRACT_W-1:0] f;
    logic [5:0]         nd;
  } s1_t;

endpackage

// File: rtl/f64_to_rec_f64_pipe_lzc52.sv
// Combinational leading-zero counter over a 52-bit fraction; an all-zero
// input reports 52.
module lzc52 (
  input  logic [51:0] i_val,
  output logic [5:0]  o_cnt
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (i_val[i]) o_cnt = 6'(51 - i);
    end
  end

endmodule

// File: rtl/f64_to_rec_f64_pipe.sv
// Two-stage binary64 -> 65-bit recoded binary64 converter, valid/ready, 1 beat/cycle.
// REC_F64_CANON_NAN_EN defined: all NaN results collapse to CANON_NAN.
module f64_to_rec_f64_pipe
  import rec_f64_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_bits,
  output logic             out_snan
);

  logic             r_v1;
  logic             r_v2;
  s1_t              r_s1;
  logic [REC_W-1:0] r_out_bits;
  logic             r_out_snan;

  logic                 w_adv1;
  logic                 w_adv2;
  logic [EXP_W-1:0]     w_e;
  logic [FRACT_W-1:0]   w_f;
  logic                 w_e_zero;
  logic                 w_e_max;
  logic                 w_f_zero;
  logic [5:0]           w_nd;
  s1_t                  w_s1_nxt;
  logic [REC_EXP_W-1:0] w_exp_norm;
  logic [REC_EXP_W-1:0] w_exp_sub;
  logic [FRACT_W-1:0]   w_fract_sub;
  logic [REC_EXP_W-1:0] w_exp;
  logic [FRACT_W-1:0]   w_fract;
  logic [REC_W-1:0]     w_rec;

  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  assign w_e      = in_bits[62:52];
  assign w_f      = in_bits[51:0];
  assign w_e_zero = (w_e == '0);
  assign w_e_max  = &w_e;
  assign w_f_zero = (w_f == '0);

  lzc52 u_lzc (
    .i_val (w_f),
    .o_cnt (w_nd)
  );

  always_comb begin
    w_s1_nxt      = '0;
    w_s1_nxt.sign = in_bits[63];
    w_s1_nxt.zero = w_e_zero && w_f_zero;
    w_s1_nxt.sub  = w_e_zero && !w_f_zero;
    w_s1_nxt.inf  = w_e_max && w_f_zero;
    w_s1_nxt.nan  = w_e_max && !w_f_zero;
    w_s1_nxt.snan = w_e_max && !w_f_zero && !w_f[51];
    w_s1_nxt.e    = w_e;
    w_s1_nxt.f    = w_f;
    w_s1_nxt.nd   = w_nd;
  end

  assign w_exp_norm  = {1'b0, r_s1.e} + NORM_BIAS_ADJ;
  assign w_exp_sub   = ({6'd0, r_s1.nd} ^ 12'hFFF) + SUB_BIAS_ADJ;
  // Shift by nd+1 drops the leading one; pre-shifting by 1 keeps the width at 52.
  assign w_fract_sub = {r_s1.f[50:0], 1'b0} << r_s1.nd;

  always_comb begin
    w_exp   = w_exp_norm;
    w_fract = r_s1.f;
    if (r_s1.sub) begin
      w_exp   = w_exp_sub;
      w_fract = w_fract_sub;
    end
    if (r_s1.zero) begin
      w_exp   = '0;
      w_fract = '0;
    end else if (r_s1.inf) begin
      w_exp   = REC_INF_EXP;
      w_fract = '0;
    end else if (r_s1.nan) begin
      w_exp   = REC_NAN_EXP;
    end
    w_rec = {r_s1.sign, w_exp, w_fract};
`ifdef REC_F64_CANON_NAN_EN
    if (r_s1.nan) w_rec = CANON_NAN;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) r_s1 <= w_s1_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2       <= 1'b0;
      r_out_bits <= '0;
      r_out_snan <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out_bits <= w_rec;
        r_out_snan <= r_s1.snan;
      end
    end
  end

  assign out_valid = r_v2;
  assign out_bits  = r_out_bits;
  assign out_snan  = r_out_snan;

endmodule

// File: tb/tb_f64_to_rec_f64_pipe.sv
// Scoreboard bench for f64_to_rec_f64_pipe: directed spec vectors, backpressure,
// mid-flight reset and randomized traffic against a value-level reference model.
module tb_f64_to_rec_f64_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_bits = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [64:0] out_bits;
  logic        out_snan;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  bit rand_rdy = 1'b0;
  bit stall_seen = 1'b0;
  bit hold = 1'b0;
  logic [65:0] held = '0;
  logic [65:0] sb[$];

  always #5 clk = ~clk;

  f64_to_rec_f64_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_snan  (out_snan)
  );

`ifdef REC_F64_CANON_NAN_EN
  localparam logic [65:0] EXP_SNAN = {1'b1, 65'h0_E008000000000000};
  localparam logic [65:0] EXP_QNAN = {1'b0, 65'h0_E008000000000000};
`else
  localparam logic [65:0] EXP_SNAN = {1'b1, 65'h0_E000000000000001};
  localparam logic [65:0] EXP_QNAN = {1'b0, 65'h1_E008000000000000};
`endif

  logic [63:0] dir_in [9] = '{
    64'h3FF0000000000000, 64'h0000000000000001, 64'h000FFFFFFFFFFFFF,
    64'h8000000000000000, 64'h7FF0000000000000, 64'h7FF0000000000001,
    64'hFFF8000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h0010000000000000};
  logic [65:0] dir_exp [9] = '{
    {1'b0, 65'h0_8000000000000000}, {1'b0, 65'h0_3CE0000000000000},
    {1'b0, 65'h0_401FFFFFFFFFFFFE}, {1'b0, 65'h1_0000000000000000},
    {1'b0, 65'h0_C000000000000000}, EXP_SNAN, EXP_QNAN,
    {1'b0, 65'h0_BFFFFFFFFFFFFFFF}, {1'b0, 65'h0_4020000000000000}};

  task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value-level model: {snan, recoded}. Recoded exponent = unbiased exponent + 2048.
  function automatic logic [65:0] ref_conv(logic [63:0] x);
    logic        s;
    int          e;
    int          p;
    int          re;
    logic [51:0] f;
    logic [51:0] fr;
    s = x[63];
    e = int'(x[62:52]);
    f = x[51:0];
    if (e == 2047) begin
      if (f == 0) return {1'b0, s, 12'hC00, 52'd0};
`ifdef REC_F64_CANON_NAN_EN
      return {!f[51], 65'h0_E008000000000000};
`else
      return {!f[51], s, 12'hE00, f};
`endif
    end
    if (e == 0 && f == 0) return {1'b0, s, 64'd0};
    if (e == 0) begin
      p = 0;
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      re = p - 1074 + 2048;
      fr = f << (52 - p);
    end else begin
      re = e - 1023 + 2048;
      fr = f;
    end
    return {1'b0, s, re[11:0], fr};
  endfunction

  function automatic logic [63:0] gen_rand();
    logic [63:0] r;
    logic [51:0] f;
    logic [10:0] e;
    logic        s;
    int          cat;
    r   = {$urandom, $urandom};
    f   = r[51:0];
    s   = r[63];
    cat = $urandom_range(0, 6);
    e   = 11'($urandom_range(1, 2046));
    case (cat)
      2: begin e = '0; f = f >> $urandom_range(0, 51); if (f == 0) f = 52'd1; end
      3: begin e = '0; f = '0; end
      4: begin e = '1; f = '0; end
      5: begin e = '1; if (f == 0) f = 52'd1; end
      6: return r;
      default: ;
    endcase
    return {s, e, f};
  endfunction

  task automatic send(logic [63:0] x, logic [65:0] exp);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_bits  = x;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 66'(sb.size()), 66'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && in_valid && !in_ready) stall_seen = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {out_valid, out_snan, out_bits[63:0]}, {1'b1, held[65], held[63:0]});
      if (hold) chk("hold_sign", 66'(out_bits[64]), 66'(held[64]));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none", {out_snan, out_bits});
        end else begin
          chk("out", {out_snan, out_bits}, sb.pop_front());
          n_out++;
        end
      end
      hold = out_valid && !out_ready;
      held = {out_snan, out_bits};
    end
  end

  initial begin
    int base;
    logic [63:0] x;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 66'(out_valid), 66'd0);
    chk("rst_in_ready", 66'(in_ready), 66'd1);
    chk("rst_out_data", {out_snan, out_bits}, 66'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 presented in cycle 0 must be valid at the output in cycle 2.
    in_valid = 1'b1;
    in_bits  = 64'h3FF0000000000000;
    sb.push_back({1'b0, 65'h0_8000000000000000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_cycle1", 66'(out_valid), 66'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", 66'(out_valid), 66'd1);
    drain();

    for (int i = 0; i < 9; i++) send(dir_in[i], dir_exp[i]);
    drain();

    stall_seen = 1'b0;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          x = gen_rand();
          send(x, ref_conv(x));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_seen", 66'(stall_seen), 66'd1);
    chk("bp_out_count", 66'(n_out - base), 66'd6);

    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = gen_rand();
      send(x, ref_conv(x));
    end
    chk("full_in_ready", 66'(in_ready), 66'd0);
    chk("full_out_valid", 66'(out_valid), 66'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", 66'(out_valid), 66'd0);
    chk("rst_mid_in_ready", 66'(in_ready), 66'd1);
    sb.delete();
    in_valid = 1'b1;
    in_bits  = 64'h4000000000000000;
    repeat (2) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_stale", 66'(out_valid), 66'd0);
    send(64'hC008000000000000, ref_conv(64'hC008000000000000));
    drain();

    base = n_out;
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      x = gen_rand();
      send(x, ref_conv(x));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
    chk("rand_out_count", 66'(n_out - base), 66'd400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
